// File: rtl/reg_wr_scoreboard_pkg.sv
// Shared types and constants for the register-write scoreboard and the ID-stage forwarding unit.
package reg_wr_scoreboard_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_EX  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   localparam logic [1:0] FWD_WB  = 2'b11;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic       valid;
      logic [4:0] rw;
      logic       is_load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rw: REG_ZERO, is_load: 1'b0};

endpackage

// File: rtl/sb_fwd_pick.sv
// Per-operand forward select: youngest matching in-flight write wins, register 0 always reads the RF.
module sb_fwd_pick
   import reg_wr_scoreboard_pkg::*;
(
   input  logic [4:0] reg_i,
   input  slot_t      ex_i,
   input  slot_t      mem_i,
   input  slot_t      wb_i,
   output logic [1:0] sel_o,
   output logic       ex_load_hit_o
);

   // MEM and WB data are always usable, so their load flags do not matter here.
   logic unused_load_bits;
   assign unused_load_bits = mem_i.is_load ^ wb_i.is_load;

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      sel_o         = FWD_RF;
      ex_load_hit_o = 1'b0;
      if (reg_i != REG_ZERO) begin
         if (ex_i.valid && (ex_i.rw == reg_i)) begin
            ex_load_hit_o = ex_i.is_load;
            sel_o         = ex_i.is_load ? FWD_RF : FWD_EX;
         end else if (mem_i.valid && (mem_i.rw == reg_i)) begin
            sel_o = FWD_MEM;
         end else if (wb_i.valid && (wb_i.rw == reg_i)) begin
            sel_o = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/reg_wr_scoreboard.sv
// Tracks in-flight GPR writes (EX/MEM/WB slots plus MDU countdowns), drives forward selects and stall.
// Optional build macro SB_PERF_CNT_EN adds saturating load-use / MDU stall-cycle counters.
module reg_wr_scoreboard
   import reg_wr_scoreboard_pkg::*;
#(
   parameter int MDU_LAT = 4,
   parameter int CNT_W   = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rw,
   input  logic        id_rfwr,
   input  logic        id_is_load,
   input  logic        id_is_mdu,
   input  logic        flush,
   output logic        stall,
   output logic [1:0]  fwd_sel_a,
   output logic [1:0]  fwd_sel_b,
`ifdef SB_PERF_CNT_EN
   output logic [31:0] perf_lu_stall,
   output logic [31:0] perf_mdu_stall,
`endif
   output logic        mdu_busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
   logic [CNT_W-1:0] cnt_q [32];
   logic [CNT_W-1:0] cnt_d [32];

   logic lu_hit_a, lu_hit_b, lu_hit;
   logic busy, mdu_raw, mdu_hz, mdu_issue;

   sb_fwd_pick u_pick_a (
      .reg_i         (id_rs),
      .ex_i          (ex_q),
      .mem_i         (mem_q),
      .wb_i          (wb_q),
      .sel_o         (fwd_sel_a),
      .ex_load_hit_o (lu_hit_a)
   );

   sb_fwd_pick u_pick_b (
      .reg_i         (id_rt),
      .ex_i          (ex_q),
      .mem_i         (mem_q),
      .wb_i          (wb_q),
      .sel_o         (fwd_sel_b),
      .ex_load_hit_o (lu_hit_b)
   );

   always_comb begin
      busy = 1'b0;
      for (int r = 1; r < 32; r++) begin
         if (cnt_q[r] != '0) busy = 1'b1;
      end
   end

   // Entry 0 is held at zero, so register 0 never raises an MDU hazard.
   assign mdu_raw   = (cnt_q[id_rs] != '0) || (cnt_q[id_rt] != '0) || (cnt_q[id_rw] != '0);
   assign mdu_hz    = mdu_raw || (id_is_mdu && busy);
   assign lu_hit    = lu_hit_a || lu_hit_b;
   assign stall     = id_valid && (lu_hit || mdu_hz);
   assign mdu_issue = id_valid && id_is_mdu && id_rfwr && !stall && (id_rw != REG_ZERO);
   assign mdu_busy  = busy;

   always_comb begin
      ex_d = SLOT_EMPTY;
      if (!stall) begin
         ex_d.valid   = id_valid && id_rfwr && !id_is_mdu && (id_rw != REG_ZERO);
         ex_d.rw      = id_rw;
         ex_d.is_load = id_is_load;
      end
      mem_d = ex_q;
      wb_d  = mem_q;

      for (int r = 0; r < 32; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CNT_ONE : '0;
      end
      cnt_d[0] = '0;
      if (mdu_issue) cnt_d[id_rw] = CNT_LOAD;

      if (flush) begin
         ex_d.valid  = 1'b0;
         mem_d.valid = 1'b0;
         wb_d.valid  = 1'b0;
         for (int r = 0; r < 32; r++) cnt_d[r] = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only; the countdown table is reset
   // (not left as uninitialised storage) because a reset must discard any pending MDU write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= SLOT_EMPTY;
         mem_q <= SLOT_EMPTY;
         wb_q  <= SLOT_EMPTY;
         for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
      end
   end

`ifdef SB_PERF_CNT_EN
   logic [31:0] perf_lu_q, perf_lu_d, perf_mdu_q, perf_mdu_d;

   // A cycle with both causes is charged to load-use only.
   always_comb begin
      perf_lu_d  = perf_lu_q;
      perf_mdu_d = perf_mdu_q;
      if (id_valid && lu_hit && (perf_lu_q != '1)) perf_lu_d = perf_lu_q + 32'd1;
      if (id_valid && mdu_hz && !lu_hit && (perf_mdu_q != '1)) perf_mdu_d = perf_mdu_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_lu_q  <= '0;
         perf_mdu_q <= '0;
      end else begin
         perf_lu_q  <= perf_lu_d;
         perf_mdu_q <= perf_mdu_d;
      end
   end

   assign perf_lu_stall  = perf_lu_q;
   assign perf_mdu_stall = perf_mdu_q;
`endif

endmodule

// File: tb/tb_reg_wr_scoreboard.sv
// Directed-vector bench for reg_wr_scoreboard (default MDU_LAT=4) with hand-computed expectations.
module tb_reg_wr_scoreboard;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_rfwr, id_is_load, id_is_mdu, flush;
   logic [4:0] id_rs, id_rt, id_rw;
   logic       stall, mdu_busy;
   logic [1:0] fwd_sel_a, fwd_sel_b;

   int checks   = 0;
   int failures = 0;

   reg_wr_scoreboard #(.MDU_LAT(4), .CNT_W(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rw      (id_rw),
      .id_rfwr    (id_rfwr),
      .id_is_load (id_is_load),
      .id_is_mdu  (id_is_mdu),
      .flush      (flush),
      .stall      (stall),
      .fwd_sel_a  (fwd_sel_a),
      .fwd_sel_b  (fwd_sel_b),
      .mdu_busy   (mdu_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rw, input logic wr, input logic ld, input logic mdu);
      id_valid   = v;
      id_rs      = rs;
      id_rt      = rt;
      id_rw      = rw;
      id_rfwr    = wr;
      id_is_load = ld;
      id_is_mdu  = mdu;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      repeat (5) tick();
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0);
      #3;
      check("reset_stall", stall, 0);
      check("reset_sel_a", fwd_sel_a, 0);
      check("reset_sel_b", fwd_sel_b, 0);
      check("reset_busy", mdu_busy, 0);
      idle();
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // ALU chain on $3: EX, then MEM, then WB forwarding.
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
      #1 check("alu_issue_stall", stall, 0);
      tick();
      set_id(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0);
      #1 check("alu_ex_sel_a", fwd_sel_a, 1);
      check("alu_ex_stall", stall, 0);
      tick();
      set_id(1'b1, 5'd3, 5'd1, 5'd9, 1'b1, 1'b0, 1'b0);
      #1 check("alu_mem_sel_a", fwd_sel_a, 2);
      tick();
      set_id(1'b1, 5'd0, 5'd3, 5'd10, 1'b1, 1'b0, 1'b0);
      #1 check("alu_wb_sel_b", fwd_sel_b, 3);
      check("alu_wb_r0_sel_a", fwd_sel_a, 0);
      drain();

      // Same register in EX and MEM: youngest (EX) wins.
      set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd4, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
      #1 check("ex_over_mem_sel_a", fwd_sel_a, 1);
      drain();

      // Load-use on $5: one stall cycle, then MEM forward of the load data.
      set_id(1'b1, 5'd1, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd6, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0);
      #1 check("lu_stall_1", stall, 1);
      check("lu_stall_sel_b", fwd_sel_b, 0);
      tick();
      #1 check("lu_stall_2", stall, 0);
      check("lu_mem_sel_b", fwd_sel_b, 2);
      drain();

      // MDU to $7: reader stalls exactly 4 cycles, busy for the same 4.
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b1);
      #1 check("mdu_issue_stall", stall, 0);
      check("mdu_issue_busy", mdu_busy, 0);
      tick();
      set_id(1'b1, 5'd7, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("mdu_raw_stall_%0d", i), stall, 1);
         check($sformatf("mdu_raw_busy_%0d", i), mdu_busy, 1);
         tick();
      end
      #1 check("mdu_done_stall", stall, 0);
      check("mdu_done_busy", mdu_busy, 0);
      check("mdu_done_sel_a", fwd_sel_a, 0);
      tick();

      // Second MDU while one is pending is a structural stall.
      set_id(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b1);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
      #1 check("mdu_struct_stall", stall, 1);
      drain();

      // Register 0 is never tracked or forwarded.
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0);
      #1 check("r0_sel_a", fwd_sel_a, 0);
      check("r0_sel_b", fwd_sel_b, 0);
      check("r0_stall", stall, 0);
      tick();
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1);
      tick();
      idle();
      #1 check("r0_mdu_busy", mdu_busy, 0);
      drain();

      // Flush kills a load in EX and a pending MDU countdown.
      set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1);
      tick();
      set_id(1'b1, 5'd1, 5'd0, 5'd2, 1'b1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd2, 5'd9, 5'd16, 1'b1, 1'b0, 1'b0);
      flush = 1'b1;
      #1 check("flush_cycle_stall", stall, 1);
      tick();
      flush = 1'b0;
      #1 check("post_flush_stall", stall, 0);
      check("post_flush_sel_a", fwd_sel_a, 0);
      check("post_flush_sel_b", fwd_sel_b, 0);
      check("post_flush_busy", mdu_busy, 0);
      drain();

      // Asynchronous reset in the middle of an MDU countdown.
      set_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b1);
      tick();
      set_id(1'b1, 5'd14, 5'd0, 5'd17, 1'b1, 1'b0, 1'b0);
      #1 check("pre_rst_stall", stall, 1);
      rst_n = 1'b0;
      #1 check("async_rst_stall", stall, 0);
      check("async_rst_busy", mdu_busy, 0);
      check("async_rst_sel_a", fwd_sel_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      #1 check("post_rst_stall", stall, 0);
      check("post_rst_busy", mdu_busy, 0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_wr_scoreboard.md
Name: reg_wr_scoreboard

Overview:
- Producer-side companion to the ID-stage forwarding logic in the 5-stage pipeline (IF/ID/EX/MEM/WB).
- Records every register write as it issues from ID and ages it through EX, MEM and WB. Holds long-latency MDU writes pending until they complete.
- Drives the ID-stage operand forward selects and the pipeline stall.

Parameters:
- MDU_LAT, 4, cycles from MDU issue (leaving ID) to MDU result valid for GPR write; legal 2..15.
- CNT_W, 4, width of per-register MDU countdown; must satisfy 2^CNT_W > MDU_LAT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  5  source A register
- id_rt  in  5  source B register
- id_rw  in  5  destination register
- id_rfwr  in  1  instruction writes GPR
- id_is_load  in  1  result available only at end of MEM
- id_is_mdu  in  1  result from multi-cycle MDU
- flush  in  1  kill all in-flight writes (exception/eret)
- stall  out  1  hold IF/ID, insert bubble into EX
- fwd_sel_a  out  2  00 RF, 01 EX(alu), 10 MEM(dm), 11 WB
- fwd_sel_b  out  2  same encoding for rt
- mdu_busy  out  1  any MDU write pending

Behaviour:
- Three stage slots, EX/MEM/WB, each holding {valid, rw, is_load}. An MDU instruction occupies its slots as non-writing (valid=0 for forwarding). Its write is tracked only in the MDU table.
- MDU table: one CNT_W-bit countdown per register 1..31. Register 0 is never tracked.
- Each clock, slots shift EX→MEM→WB. WB is dropped.
- EX loads {id_valid&id_rfwr&!id_is_mdu&(id_rw!=0), id_rw, id_is_load} when stall=0. When stall=1, EX loads a bubble (valid=0).
- MDU issue (id_valid&id_is_mdu&id_rfwr&!stall, id_rw!=0): countdown[id_rw] <= MDU_LAT. Nonzero counts decrement by 1 per cycle.
- Write completes when the count reaches 0. The MDU writes the RF directly that cycle, and ID reads the new value next cycle (RF write-first is not assumed).
- stall (combinational), asserted when id_valid and any of:
  - rs or rt (nonzero) matches a valid EX slot with is_load=1 (load-use)
  - rs/rt/rw (nonzero) has countdown≠0 (RAW/WAW on MDU)
  - id_is_mdu while mdu_busy (single MDU)
- Forward select priority, per operand, when the register is nonzero: EX(01) > MEM(10) > WB(11) > RF(00).
  - An EX match with is_load gives 00; stall is asserted anyway.
  - A MEM match with is_load is legal: the dm result selects 10.
- Register 0 always selects 00.
- fwd_sel is don't-care when id_valid=0 but must still be deterministic (same rule applies).
- flush (synchronous, takes priority over the shift): all slot valids ← 0 and all countdowns ← 0 next cycle. stall may be high during flush; the bubble is irrelevant.
- Reset: all slots invalid, all countdowns 0. stall=0, fwd_sel_a=fwd_sel_b=00, mdu_busy=0.
- Reset mid-MDU discards the pending write. The MDU itself is reset by the same rst_n.
- Simultaneous events:
  - MDU issue to register r while the countdown of r is 0: count loads MDU_LAT with no decrement that cycle.
  - Same-register writes in EX and MEM: EX wins (youngest).

Optional Feature:
- SB_PERF_CNT_EN defined:
  - Adds outputs perf_lu_stall (32-bit load-use stall cycles) and perf_mdu_stall (32-bit MDU-caused stall cycles).
  - Both counters saturate at all-ones, clear on reset and are unaffected by flush.
  - When both causes are present, the cycle counts as load-use only.
- Undefined: neither port nor counters exist. All other behaviour is identical.

Decomposition:
- Shared package:
  - fwd_sel encoding constants FWD_RF/FWD_EX/FWD_MEM/FWD_WB (shared with the forwarding unit)
  - slot typedef {valid, rw[4:0], is_load}
  - REG_ZERO constant
- One sub-module, sb_fwd_pick: per-operand match/priority encoder, instantiated for rs and rt.

Test Plan:
- `add $3` then `sub` using rs=$3 back-to-back → fwd_sel_a=01, stall=0. One cycle later, an instruction reading $3 sees 10; the next sees 11.
- `lw $5` then `add` with rt=$5 → stall=1 for exactly 1 cycle, then fwd_sel_b=10, stall=0.
- MDU to $7 (MDU_LAT=4), then a reader of $7 → stall high 4 cycles, mdu_busy high 4 cycles. The reader then issues with fwd_sel=00.
- Write to $0 followed by a reader of $0 → fwd_sel=00, stall=0. Also, MDU to $0 → mdu_busy stays 0.
- `lw $2` in EX with flush asserted → next cycle stall=0 and fwd_sel=00 for a reader of $2. Pending MDU countdowns are also cleared.
- rst_n low mid-MDU → outputs 00/0 asynchronously. After release, a reader of the MDU destination is not stalled.
